// File: rtl/digit_glyph_renderer.sv
// Multi-digit BCD glyph overlay for the VGA raster.
// Two-stage pixel pipeline with frame-synchronous value commit.
module digit_glyph_renderer #(
  parameter int         NUM_DIGITS = 3,
  parameter int         SCALE_LOG2 = 2,
  parameter int         ORIGIN_X   = 256,
  parameter int         ORIGIN_Y   = 200,
  parameter logic [5:0] BG_COLOR   = 6'b000000,
  parameter bit         BLANK_LZ   = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    frame_start,
  input  logic                    pix_valid,
  input  logic [9:0]              pix_x,
  input  logic [9:0]              pix_y,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    value_valid,
  output logic                    value_ready,
  output logic [3:0]              rom_digit,
  output logic [4:0]              rom_row,
  output logic [4:0]              rom_col,
  input  logic [5:0]              rom_data,
  output logic [5:0]              rgb_out,
  output logic                    rgb_valid
);

  localparam int VW = 4 * NUM_DIGITS;
  localparam int DW = 11 - 3 - SCALE_LOG2;
  localparam logic signed [10:0] BOX_W =
    11'(NUM_DIGITS * (8 << SCALE_LOG2));
  localparam logic signed [10:0] BOX_H =
    11'(16 << SCALE_LOG2);
  localparam logic signed [10:0] OX = 11'(ORIGIN_X);
  localparam logic signed [10:0] OY = 11'(ORIGIN_Y);

  typedef enum logic {
    S_IDLE,
    S_PEND
  } hs_t;

  typedef struct packed {
    logic       v;
    logic       hit;
    logic [3:0] dig;
    logic [4:0] row;
    logic [4:0] col;
  } s1_t;

  hs_t st, st_nx;
  logic [VW-1:0] disp, disp_nx;
  logic [VW-1:0] pend, pend_nx;
  logic          xfer;

  assign value_ready = (st == S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st   <= S_IDLE;
      disp <= '0;
      pend <= '0;
    end else begin
      st   <= st_nx;
      disp <= disp_nx;
      pend <= pend_nx;
    end
  end

  // display only ever changes on frame_start, so no tearing
  always_comb begin
    st_nx   = st;
    disp_nx = disp;
    pend_nx = pend;
    xfer    = value_valid & (st == S_IDLE);
    unique case (st)
      S_IDLE: begin
        if (xfer) begin
          if (frame_start) begin
            disp_nx = value_in;
          end else begin
            pend_nx = value_in;
            st_nx   = S_PEND;
          end
        end
      end
      S_PEND: begin
        if (frame_start) begin
          disp_nx = pend;
          st_nx   = S_IDLE;
        end
      end
    endcase
  end

  logic signed [10:0] dx, dy;
  logic               in_box;
  logic [DW-1:0]      dsel;

  assign dx = $signed({1'b0, pix_x}) - OX;
  assign dy = $signed({1'b0, pix_y}) - OY;
  assign dsel = dx[10 -: DW];

  assign in_box = pix_valid
                & ~dx[10] & (dx < BOX_W)
                & ~dy[10] & (dy < BOX_H);

  logic [3:0]            nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] blk;
  logic                  lz;

  // lz tracks "this and every more-significant nibble is zero"
  always_comb begin
    lz = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nib[i] = disp[VW-1-4*i -: 4];
      lz     = lz & (nib[i] == 4'd0);
      blk[i] = (nib[i] > 4'd9)
             || (BLANK_LZ && (i < NUM_DIGITS - 1) && lz);
    end
  end

  logic [3:0] sel_nib;
  logic       sel_blk;

  always_comb begin
    sel_nib = '0;
    sel_blk = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dsel == DW'(i)) begin
        sel_nib = nib[i];
        sel_blk = blk[i];
      end
    end
  end

  s1_t s1, s1_nx;
  logic hit;

  assign hit = in_box & ~sel_blk;

  always_comb begin
    s1_nx     = '0;
    s1_nx.v   = pix_valid;
    s1_nx.hit = hit;
    if (hit) begin
      s1_nx.dig = sel_nib;
      s1_nx.row = dy[SCALE_LOG2 +: 5];
      s1_nx.col = {2'b00, dx[SCALE_LOG2 +: 3]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
    end else begin
      s1 <= s1_nx;
    end
  end

  assign rom_digit = s1.dig;
  assign rom_row   = s1.row;
  assign rom_col   = s1.col;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_out   <= '0;
      rgb_valid <= 1'b0;
    end else begin
      rgb_out   <= s1.hit ? rom_data : BG_COLOR;
      rgb_valid <= s1.v;
    end
  end

endmodule

// File: tb/tb_digit_glyph_renderer.sv
// Self-checking bench for digit_glyph_renderer.
// Arithmetic glyph model plus directed literal checks.
module tb_digit_glyph_renderer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        frame_start;
  logic        pix_valid;
  logic [9:0]  pix_x, pix_y;
  logic [11:0] value_in;
  logic        value_valid;
  logic        value_ready;
  logic [3:0]  rom_digit;
  logic [4:0]  rom_row, rom_col;
  logic [5:0]  rom_data;
  logic [5:0]  rgb_out;
  logic        rgb_valid;

  int nchk = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [5:0] rom_f(input int d, input int r, input int c);
    return 6'(((d * 7 + r * 3 + c * 5) % 63) + 1);
  endfunction

  assign rom_data = rom_f(int'(rom_digit), int'(rom_row), int'(rom_col));

  digit_glyph_renderer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_start(frame_start),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .value_in   (value_in),
    .value_valid(value_valid),
    .value_ready(value_ready),
    .rom_digit  (rom_digit),
    .rom_row    (rom_row),
    .rom_col    (rom_col),
    .rom_data   (rom_data),
    .rgb_out    (rgb_out),
    .rgb_valid  (rgb_valid)
  );

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic       v;
    logic       hit;
    logic [3:0] dig;
    logic [4:0] row;
    logic [4:0] col;
  } px_t;

  // Box is 96x64 at (256,200); 32x64 pixels per digit, 4x4 per cell.
  function automatic px_t exp_pix(input int x, input int y,
                                  input logic v, input logic [11:0] dv);
    px_t p;
    int dx, dy, d, nib;
    bit lead, blank;
    p = '0;
    p.v = v;
    dx = x - 256;
    dy = y - 200;
    if (v && dx >= 0 && dx < 96 && dy >= 0 && dy < 64) begin
      d = dx / 32;
      nib = int'((dv >> (4 * (2 - d))) & 12'hF);
      lead = 1'b1;
      for (int j = 0; j < d; j++)
        if (((dv >> (4 * (2 - j))) & 12'hF) != 12'h0) lead = 1'b0;
      blank = (nib > 9) || (d < 2 && nib == 0 && lead);
      if (!blank) begin
        p.hit = 1'b1;
        p.dig = 4'(nib);
        p.row = 5'(dy / 4);
        p.col = 5'((dx / 4) % 8);
      end
    end
    return p;
  endfunction

  px_t         e1;
  logic [5:0]  e_rgb;
  logic        e_rv;
  logic [11:0] mdisp, mpend;
  logic        mready;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e1     <= '0;
      e_rgb  <= '0;
      e_rv   <= 1'b0;
      mdisp  <= '0;
      mpend  <= '0;
      mready <= 1'b1;
    end else begin
      e_rgb <= e1.hit ? rom_f(int'(e1.dig), int'(e1.row), int'(e1.col)) : 6'd0;
      e_rv  <= e1.v;
      e1    <= exp_pix(int'(pix_x), int'(pix_y), pix_valid, mdisp);
      if (mready && value_valid) begin
        if (frame_start) mdisp <= value_in;
        else begin
          mpend  <= value_in;
          mready <= 1'b0;
        end
      end else if (!mready && frame_start) begin
        mdisp  <= mpend;
        mready <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_rgb_valid", int'(rgb_valid), int'(e_rv));
      chk("m_rgb_out", int'(rgb_out), int'(e_rgb));
      chk("m_rom_digit", int'(rom_digit), int'(e1.dig));
      chk("m_rom_row", int'(rom_row), int'(e1.row));
      chk("m_rom_col", int'(rom_col), int'(e1.col));
      chk("m_value_ready", int'(value_ready), int'(mready));
    end
  end

  task automatic drv(input int x, input int y, input logic v);
    pix_x = 10'(x);
    pix_y = 10'(y);
    pix_valid = v;
    @(negedge clk);
  endtask

  task automatic idle();
    drv(0, 0, 1'b0);
  endtask

  task automatic chk_rom(input string nm, input int d, input int r, input int c);
    chk({nm, "_digit"}, int'(rom_digit), d);
    chk({nm, "_row"}, int'(rom_row), r);
    chk({nm, "_col"}, int'(rom_col), c);
  endtask

  task automatic commit_now(input logic [11:0] v);
    value_in = v;
    value_valid = 1'b1;
    frame_start = 1'b1;
    idle();
    value_valid = 1'b0;
    frame_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, first, last;
    reset_n = 1'b0;
    frame_start = 1'b0;
    pix_valid = 1'b0;
    pix_x = '0;
    pix_y = '0;
    value_in = '0;
    value_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rgb_out", int'(rgb_out), 0);
    chk("rst_rgb_valid", int'(rgb_valid), 0);
    chk_rom("rst_rom", 0, 0, 0);
    chk("rst_value_ready", int'(value_ready), 1);
    reset_n = 1'b1;
    chk_en = 1'b1;

    drv(256, 200, 1'b1);
    chk_rom("blank_d0", 0, 0, 0);
    idle();
    chk("blank_d0_rgb", int'(rgb_out), 0);
    drv(320, 200, 1'b1);
    chk_rom("zero_d2", 0, 0, 0);
    idle();
    chk("zero_d2_rgb", int'(rgb_out), 1);

    value_in = 12'h123;
    value_valid = 1'b1;
    idle();
    chk("defer_ready", int'(value_ready), 0);
    value_in = 12'h777;
    drv(264, 204, 1'b1);
    chk_rom("defer_old", 0, 0, 0);
    idle();
    chk("defer_old_rgb", int'(rgb_out), 0);
    value_valid = 1'b0;
    frame_start = 1'b1;
    idle();
    frame_start = 1'b0;
    chk("commit_ready", int'(value_ready), 1);
    drv(264, 204, 1'b1);
    chk_rom("commit_new", 1, 1, 2);
    idle();
    chk("commit_new_rgb", int'(rgb_out), 21);

    commit_now(12'h456);
    chk("simul_ready", int'(value_ready), 1);
    drv(288, 263, 1'b1);
    chk_rom("simul", 5, 15, 0);
    idle();
    chk("simul_rgb", int'(rgb_out), 18);

    drv(255, 200, 1'b1);
    chk_rom("edge_x255", 0, 0, 0);
    idle();
    chk("edge_x255_rgb", int'(rgb_out), 0);
    drv(352, 200, 1'b1);
    chk_rom("edge_x352", 0, 0, 0);
    idle();
    chk("edge_x352_rgb", int'(rgb_out), 0);
    drv(300, 199, 1'b1);
    chk_rom("edge_y199", 0, 0, 0);
    idle();
    chk("edge_y199_rgb", int'(rgb_out), 0);
    drv(300, 264, 1'b1);
    chk_rom("edge_y264", 0, 0, 0);
    idle();
    chk("edge_y264_rgb", int'(rgb_out), 0);
    drv(351, 263, 1'b1);
    chk_rom("edge_in", 6, 15, 7);
    idle();
    chk("edge_in_rgb", int'(rgb_out), 60);

    commit_now(12'h1A3);
    drv(290, 210, 1'b1);
    chk_rom("bad_nib", 0, 0, 0);
    idle();
    chk("bad_nib_rgb", int'(rgb_out), 0);
    drv(256, 200, 1'b1);
    chk_rom("bad_nib_d0", 1, 0, 0);
    idle();

    commit_now(12'h007);
    drv(296, 200, 1'b1);
    idle();
    chk("lz_d1_rgb", int'(rgb_out), 0);
    drv(320, 200, 1'b1);
    chk_rom("lz_d2", 7, 0, 0);
    idle();
    chk("lz_d2_rgb", int'(rgb_out), 50);

    cnt = 0;
    first = -1;
    last = -1;
    for (int k = 0; k < 99; k++) begin
      if (k < 96) drv(256 + k, 230, 1'b1);
      else idle();
      if (rgb_valid) begin
        cnt++;
        if (first < 0) first = k;
        last = k;
      end
    end
    chk("burst_len", cnt, 96);
    chk("burst_first", first, 1);
    chk("burst_last", last, 96);

    value_in = 12'h999;
    value_valid = 1'b1;
    idle();
    value_valid = 1'b0;
    chk("rst_pend_ready", int'(value_ready), 0);
    drv(320, 210, 1'b1);
    drv(320, 210, 1'b1);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_rgb_valid", int'(rgb_valid), 0);
    chk("arst_rgb_out", int'(rgb_out), 0);
    chk("arst_value_ready", int'(value_ready), 1);
    chk_rom("arst_rom", 0, 0, 0);
    @(negedge clk);
    idle();
    idle();
    reset_n = 1'b1;
    idle();
    frame_start = 1'b1;
    idle();
    frame_start = 1'b0;
    chk("post_rst_ready", int'(value_ready), 1);
    drv(320, 200, 1'b1);
    chk_rom("post_rst", 0, 0, 0);
    idle();
    chk("post_rst_rgb", int'(rgb_out), 1);
    idle();
    idle();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
